// File: rtl/maze_pkg.sv
// Shared types and constants for the maze router datapath.
package maze_pkg;

  localparam int NUM_PORTS    = 5;
  localparam int PKT_W        = 23;
  localparam int QOS_POS      = 8;
  localparam int STARVE_LIMIT = 4;

  // Packet field layout
  localparam int TGT_LSB  = 0;
  localparam int TGT_W    = 4;
  localparam int SRC_LSB  = 4;
  localparam int SRC_W    = 4;
  localparam int TYPE_LSB = 20;
  localparam int TYPE_W   = 3;

  // Port / direction indices
  localparam int DIR_N = 0;
  localparam int DIR_W = 1;
  localparam int DIR_S = 2;
  localparam int DIR_E = 3;
  localparam int DIR_B = 4;

  typedef logic [PKT_W-1:0] pkt_t;

  function automatic logic onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Handshake bundle between the router input buffers, the allocator and the output links.
interface switch_allocator_if;
  import maze_pkg::*;

  logic [NUM_PORTS-1:0]       in_valid;
  logic [NUM_PORTS*5-1:0]     in_route_req;
  logic [NUM_PORTS*PKT_W-1:0] in_pkt;
  logic [NUM_PORTS-1:0]       in_grant;
  logic [NUM_PORTS-1:0]       out_valid;
  logic [NUM_PORTS*PKT_W-1:0] out_pkt;
  logic [NUM_PORTS-1:0]       out_ready;
  logic                       err_route;

  modport slave (
    input  in_valid, in_route_req, in_pkt, out_ready,
    output in_grant, out_valid, out_pkt, err_route
  );

  modport master (
    output in_valid, in_route_req, in_pkt, out_ready,
    input  in_grant, out_valid, out_pkt, err_route
  );

endinterface

// File: rtl/switch_allocator_qos_rr_arbiter.sv
// Per-output arbiter: QoS-first pool with starvation escape, then round-robin.
module qos_rr_arbiter
  import maze_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] qos,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 gnt_valid
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  localparam logic [2:0] LAST  = 3'(NUM_PORTS - 1);

  logic [2:0]           rr_ptr_d, rr_ptr_q;
  logic [2:0]           starve_cnt_d, starve_cnt_q;
  logic [2:0]           win, idx;
  logic [3:0]           sum;
  logic [NUM_PORTS-1:0] hi, lo, pool;
  logic                 found;

  // Pick the pool, scan it from rr_ptr with wrap, and compute pointer/counter updates
  always_comb begin
    hi    = req & qos;
    lo    = req & ~qos;
    pool  = ((|hi) && (starve_cnt_q < LIMIT)) ? hi : req;
    grant = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, rr_ptr_q} + 4'(k);
      idx = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
      if (en && !found && pool[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
    gnt_valid    = found;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (found) begin
      rr_ptr_d = (win == LAST) ? 3'd0 : win + 3'd1;
      if (qos[win] && (|lo))
        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 3'd1;
      else
        starve_cnt_d = 3'd0;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Output-port allocator and crossbar: request transpose, per-output arbiters,
// single-entry output holding slots and sticky route error.
module switch_allocator
  import maze_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  switch_allocator_if.slave bus
);

  logic [NUM_PORTS-1:0] req_by_out [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_by_out [NUM_PORTS];
  logic [NUM_PORTS-1:0] qos, route_bad, slot_free, gnt_valid, in_grant_c;
  logic [NUM_PORTS-1:0] out_valid_d, out_valid_q;
  pkt_t                 out_pkt_d [NUM_PORTS];
  pkt_t                 out_pkt_q [NUM_PORTS];
  logic                 err_route_d, err_route_q;
  logic [4:0]           route_i;
  logic                 uturn_i, route_ok_i;

  // Validate each route_req and transpose into per-output request vectors
  always_comb begin
    route_bad  = '0;
    qos        = '0;
    route_i    = '0;
    uturn_i    = 1'b0;
    route_ok_i = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) req_by_out[o] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      route_i      = bus.in_route_req[i*5 +: 5];
      qos[i]       = bus.in_pkt[i*PKT_W + QOS_POS];
      // Only the local port may route back to itself
      uturn_i      = (i != DIR_B) && route_i[i];
      route_ok_i   = onehot5(route_i) && !uturn_i;
      route_bad[i] = bus.in_valid[i] && !route_ok_i;
      for (int o = 0; o < NUM_PORTS; o++)
        req_by_out[o][i] = bus.in_valid[i] && route_ok_i && route_i[o];
    end
  end

  assign slot_free = ~out_valid_q | bus.out_ready;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    qos_rr_arbiter u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (slot_free[o]),
      .req       (req_by_out[o]),
      .qos       (qos),
      .grant     (gnt_by_out[o]),
      .gnt_valid (gnt_valid[o])
    );
  end

  // Merge per-output grants into the pop strobe; held low during reset
  always_comb begin
    in_grant_c = '0;
    for (int o = 0; o < NUM_PORTS; o++) in_grant_c = in_grant_c | gnt_by_out[o];
    bus.in_grant = rst_n ? in_grant_c : '0;
  end

  // Slot next state: load on grant (covers pop+refill), clear on pop alone, else hold
  always_comb begin
    err_route_d = err_route_q | (|route_bad);
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid_d[o] = out_valid_q[o];
      out_pkt_d[o]   = out_pkt_q[o];
      if (gnt_valid[o]) begin
        out_valid_d[o] = 1'b1;
        out_pkt_d[o]   = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          if (gnt_by_out[o][i]) out_pkt_d[o] = out_pkt_d[o] | bus.in_pkt[i*PKT_W +: PKT_W];
      end else if (bus.out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  // Slot and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      err_route_q <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) out_pkt_q[o] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      err_route_q <= err_route_d;
      for (int o = 0; o < NUM_PORTS; o++) out_pkt_q[o] <= out_pkt_d[o];
    end
  end

  // Flatten slot contents onto the output bus
  always_comb begin
    bus.out_pkt = '0;
    for (int o = 0; o < NUM_PORTS; o++) bus.out_pkt[o*PKT_W +: PKT_W] = out_pkt_q[o];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.err_route = err_route_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: vector table plus hand-written multi-cycle sequences.
module tb_switch_allocator;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  switch_allocator_if bus ();

  switch_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [4:0] vld;
    logic [24:0] route;
    logic [4:0] qos;
    logic [4:0] rdy;
    logic [4:0] exp_gnt;
    logic [4:0] exp_ov;
    logic       exp_err;
    int         slot;
    int         src;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] RN = 5'b00001;
  localparam logic [4:0] RW = 5'b00010;
  localparam logic [4:0] RS = 5'b00100;
  localparam logic [4:0] RE = 5'b01000;
  localparam logic [4:0] RB = 5'b10000;

  function automatic logic [24:0] route5(input logic [4:0] d0, d1, d2, d3, d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [22:0] pkt_of(input int i, input logic q);
    return {3'b0, 4'(i + 1), 7'b0, q, 8'(8'hA0 + i)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] vld, input logic [24:0] route,
                       input logic [4:0] qos, input logic [4:0] rdy);
    bus.in_valid     = vld;
    bus.in_route_req = route;
    for (int i = 0; i < 5; i++) bus.in_pkt[i*23 +: 23] = pkt_of(i, qos[i]);
    bus.out_ready    = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'b0, 25'b0, 5'b0, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic rs, input logic [4:0] vld, input logic [24:0] route,
                     input logic [4:0] qos, input logic [4:0] rdy, input logic [4:0] eg,
                     input logic [4:0] eov, input logic ee, input int slot, input int src);
    vec_t v;
    v.do_rst = rs; v.vld = vld; v.route = route; v.qos = qos; v.rdy = rdy;
    v.exp_gnt = eg; v.exp_ov = eov; v.exp_err = ee; v.slot = slot; v.src = src;
    vecs.push_back(v);
  endtask

  initial begin
    logic [24:0] r;

    // Round-robin on B among inputs 0,1,2
    r = route5(RB, RB, RB, 5'b0, 5'b0);
    add(1, 5'b00111, r, 5'b0, 5'b11111, 5'b00001, 5'b00000, 0, -1, 0);
    add(0, 5'b00111, r, 5'b0, 5'b11111, 5'b00010, 5'b10000, 0,  4, 0);
    add(0, 5'b00111, r, 5'b0, 5'b11111, 5'b00100, 5'b10000, 0,  4, 1);
    add(0, 5'b00111, r, 5'b0, 5'b11111, 5'b00001, 5'b10000, 0,  4, 2);
    add(0, 5'b00111, r, 5'b0, 5'b11111, 5'b00010, 5'b10000, 0,  4, 0);
    // QoS input 1 vs non-QoS input 3 on S, starvation escape after 4 grants
    r = route5(5'b0, RS, 5'b0, RS, 5'b0);
    add(1, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00000, 0, -1, 0);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00100, 0,  2, 1);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00100, 0,  2, 1);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00100, 0,  2, 1);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b01000, 5'b00100, 0,  2, 1);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00100, 0,  2, 3);
    add(0, 5'b01010, r, 5'b00010, 5'b11111, 5'b00010, 5'b00100, 0,  2, 1);
    // Malformed, zero and U-turn routes
    r = route5(5'b0, 5'b0, 5'b01010, 5'b0, 5'b0);
    add(1, 5'b00100, r, 5'b0, 5'b11111, 5'b00000, 5'b00000, 0, -1, 0);
    add(0, 5'b00100, r, 5'b0, 5'b11111, 5'b00000, 5'b00000, 1, -1, 0);
    r = route5(RN, 5'b0, 5'b0, 5'b0, 5'b0);
    add(0, 5'b00001, r, 5'b0, 5'b11111, 5'b00000, 5'b00000, 1, -1, 0);
    r = route5(RE, 5'b0, 5'b0, 5'b0, RB);
    add(0, 5'b10101, r, 5'b0, 5'b11111, 5'b10001, 5'b00000, 1, -1, 0);
    add(0, 5'b00000, r, 5'b0, 5'b11111, 5'b00000, 5'b11000, 1,  3, 0);
    add(0, 5'b00000, r, 5'b0, 5'b11111, 5'b00000, 5'b00000, 1, -1, 0);

    // Reset state, with a request present that must not be granted
    rst_n = 1'b0;
    drive(5'b00001, route5(RE, 5'b0, 5'b0, 5'b0, 5'b0), 5'b0, 5'b0);
    #12;
    chk("rst in_grant", 32'(bus.in_grant), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst err_route", 32'(bus.err_route), 32'h0);
    chk("rst out_pkt", 32'(bus.out_pkt == '0), 32'h1);
    bus.in_valid = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N requests E, 1-cycle latency into slot 3
    bus.in_valid = 5'b00001;
    bus.in_pkt[22:0] = 23'h0ABCDE;
    @(negedge clk);
    chk("t1 grant", 32'(bus.in_grant), 32'h01);
    chk("t1 ov before", 32'(bus.out_valid), 32'h00);
    @(posedge clk); #1;
    bus.in_pkt[22:0] = 23'h012345;

    // Slot 3 stalled for 5 cycles while input 0 keeps requesting E
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4 stall%0d grant", c), 32'(bus.in_grant), 32'h0);
      chk($sformatf("t4 stall%0d ov", c), 32'(bus.out_valid), 32'h08);
      chk($sformatf("t4 stall%0d pkt", c), 32'(bus.out_pkt[3*23 +: 23]), 32'h0ABCDE);
      @(posedge clk); #1;
    end
    bus.out_ready = 5'b01000;
    @(negedge clk);
    chk("t4 refill grant", 32'(bus.in_grant), 32'h01);
    @(posedge clk); #1;
    bus.in_valid = 5'b0;
    @(negedge clk);
    chk("t4 refill pkt", 32'(bus.out_pkt[3*23 +: 23]), 32'h012345);
    chk("t4 refill ov", 32'(bus.out_valid), 32'h08);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 drain ov", 32'(bus.out_valid), 32'h00);
    @(posedge clk); #1;

    // Fill all five slots, then async reset mid-cycle
    drive(5'b11111, route5(RE, RS, RN, RW, RB), 5'b0, 5'b0);
    @(negedge clk);
    chk("t6 fill grant", 32'(bus.in_grant), 32'h1F);
    @(posedge clk); #1;
    bus.in_valid = 5'b0;
    @(negedge clk);
    chk("t6 full ov", 32'(bus.out_valid), 32'h1F);
    #2;
    bus.in_valid = 5'b11111;
    rst_n = 1'b0;
    #1;
    chk("t6 async ov", 32'(bus.out_valid), 32'h0);
    chk("t6 async grant", 32'(bus.in_grant), 32'h0);
    chk("t6 async pkt", 32'(bus.out_pkt == '0), 32'h1);
    @(negedge clk);
    bus.in_valid = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(5'b01010, route5(5'b0, RS, 5'b0, RS, 5'b0), 5'b0, 5'b11111);
    @(negedge clk);
    chk("t6 rr restart", 32'(bus.in_grant), 32'h02);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].do_rst) do_reset();
      drive(vecs[n].vld, vecs[n].route, vecs[n].qos, vecs[n].rdy);
      @(negedge clk);
      chk($sformatf("v%0d grant", n), 32'(bus.in_grant), 32'(vecs[n].exp_gnt));
      chk($sformatf("v%0d ov", n), 32'(bus.out_valid), 32'(vecs[n].exp_ov));
      chk($sformatf("v%0d err", n), 32'(bus.err_route), 32'(vecs[n].exp_err));
      if (vecs[n].slot >= 0)
        chk($sformatf("v%0d pkt", n), 32'(bus.out_pkt[vecs[n].slot*23 +: 23]),
            32'(pkt_of(vecs[n].src, vecs[n].qos[vecs[n].src])));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
